// File: rtl/bram_fifo_ctrl.sv
// Single-clock valid/ready FIFO controller over one sram1024x18 (port A write, port B read).
// A 2-entry prefetch buffer hides SRAM read latency. Optional MSB parity: define BRAM_FIFO_PARITY_EN.
module bram_fifo_ctrl #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 18,
  parameter int unsigned AFULL_TH  = 1020,
  parameter int unsigned AEMPTY_TH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              parity_err,
  output logic              sram_cen_a,
  output logic              sram_wen_a,
  output logic [ADDR_W-1:0] sram_addr_a,
  output logic [DATA_W-1:0] sram_wmsk_a,
  output logic [DATA_W-1:0] sram_wdata_a,
  output logic              sram_cen_b,
  output logic              sram_wen_b,
  output logic [ADDR_W-1:0] sram_addr_b,
  output logic [DATA_W-1:0] sram_wmsk_b,
  output logic [DATA_W-1:0] sram_wdata_b,
  input  logic [DATA_W-1:0] sram_rdata_b
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0]  mem_cnt, mem_cnt_n, count_n;
  logic [1:0]        obuf_cnt, obuf_cnt_n, obuf_base;
  logic              inflight;
  logic [DATA_W-1:0] obuf0, obuf1, obuf0_n, obuf1_n, wword;
  logic [2:0]        occ, occ_left;
  logic              push, pop, issue;

`ifdef BRAM_FIFO_PARITY_EN
  // MSB becomes even parity of the low bits (XOR with the old MSB cancels it out)
  assign wword = s_data ^ {s_data[DATA_W-1] ^ (^s_data[DATA_W-2:0]), {(DATA_W-1){1'b0}}};
`else
  assign wword = s_data;
`endif

  // Handshakes, read issue and next-state of counters and prefetch buffer
  always_comb begin
    push       = s_valid & s_ready;
    pop        = m_valid & m_ready;
    occ        = {1'b0, obuf_cnt} + {2'b00, inflight};
    occ_left   = occ - {2'b00, pop};
    issue      = (mem_cnt != '0) && (occ_left < 3'd2);
    mem_cnt_n  = mem_cnt + CNT_W'(push) - CNT_W'(issue);
    count_n    = count + CNT_W'(push) - CNT_W'(pop);
    obuf_cnt_n = obuf_cnt + {1'b0, inflight} - {1'b0, pop};
    obuf_base  = obuf_cnt - {1'b0, pop};
    obuf0_n    = obuf0;
    obuf1_n    = obuf1;
    if (pop) obuf0_n = obuf1;
    if (inflight) begin
      if (obuf_base == 2'd0) obuf0_n = sram_rdata_b;
      else                   obuf1_n = sram_rdata_b;
    end
  end

  assign sram_cen_a   = ~push;
  assign sram_wen_a   = ~push;
  assign sram_addr_a  = wptr;
  assign sram_wmsk_a  = '0;
  assign sram_wdata_a = wword;

  assign sram_cen_b   = ~issue;
  assign sram_wen_b   = 1'b1;
  assign sram_addr_b  = rptr;
  assign sram_wmsk_b  = '1;
  assign sram_wdata_b = '0;

  assign m_data = obuf0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      mem_cnt      <= '0;
      obuf_cnt     <= '0;
      inflight     <= 1'b0;
      obuf0        <= '0;
      obuf1        <= '0;
      count        <= '0;
      s_ready      <= 1'b0;
      m_valid      <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (push)  wptr <= wptr + ADDR_W'(1);
      if (issue) rptr <= rptr + ADDR_W'(1);
      mem_cnt      <= mem_cnt_n;
      inflight     <= issue;
      obuf_cnt     <= obuf_cnt_n;
      obuf0        <= obuf0_n;
      obuf1        <= obuf1_n;
      count        <= count_n;
      s_ready      <= count_n < CNT_W'(DEPTH);
      m_valid      <= obuf_cnt_n != 2'd0;
      almost_full  <= count_n >= CNT_W'(AFULL_TH);
      almost_empty <= count_n <= CNT_W'(AEMPTY_TH);
    end
  end

`ifdef BRAM_FIFO_PARITY_EN
  // Sticky: any captured word with odd overall parity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          parity_err <= 1'b0;
    else if (inflight && ^sram_rdata_b)  parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
